// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generation, in-order imem requests, and a small
// ring pairing each response with its PC before handing {pc, instr} to decode.
module fetch_stage #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [31:0]     id_instr_o
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW     = $clog2(DEPTH + 1);
  localparam logic [CntW:0]   DepthSum = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CntW-1:0] cnt_q, cnt_d;    // allocated entries
  logic [CntW-1:0] pend_q, pend_d;  // allocated but not yet filled
  logic [CntW-1:0] drop_q, drop_d;  // wrong-path responses still to discard
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [XLEN-1:0] slot_pc_q    [DEPTH];
  logic [31:0]     slot_instr_q [DEPTH];

  logic req_room;
  logic accept;
  logic xfer;
  logic rsp_fill;

  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Request side uses only registered occupancy, never imem_req_ready_i.
  always_comb begin
    req_room         = ({1'b0, cnt_q} + {1'b0, drop_q}) < DepthSum;
    imem_req_valid_o = reset_ni && !redirect_valid_i && req_room;
    imem_req_addr_o  = pc_q;
    id_valid_o       = reset_ni && filled_q[head_q];
    id_pc_o          = slot_pc_q[head_q];
    id_instr_o       = slot_instr_q[head_q];
  end

  assign accept   = imem_req_valid_o && imem_req_ready_i;
  assign xfer     = id_valid_o && id_ready_i;
  assign rsp_fill = imem_rsp_valid_i && (drop_q == '0) && !redirect_valid_i;

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    drop_d   = drop_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    filled_d = filled_q;
    if (redirect_valid_i) begin
      // Every unfilled entry becomes a response to discard; a same-cycle response
      // retires one of them immediately.
      pc_d     = {redirect_pc_i[XLEN-1:2], 2'b00};
      cnt_d    = '0;
      pend_d   = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      filled_d = '0;
      drop_d   = drop_q + pend_q - CntW'(imem_rsp_valid_i);
    end else begin
      if (accept) begin
        filled_d[tail_q] = 1'b0;
        tail_d           = tail_q + PtrW'(1);
        pc_d             = pc_q + XLEN'(4);
      end
      if (imem_rsp_valid_i) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CntW'(1);
        end else begin
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + PtrW'(1);
        end
      end
      if (xfer) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PtrW'(1);
      end
      cnt_d  = cnt_q + CntW'(accept) - CntW'(xfer);
      pend_d = pend_q + CntW'(accept) - CntW'(rsp_fill);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      filled_q <= '0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      filled_q <= filled_d;
    end
  end

  // Payload storage needs no reset; validity lives in filled_q.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      slot_pc_q[tail_q] <= pc_q;
    end
    if (rsp_fill) begin
      slot_instr_q[fill_q] <= imem_rsp_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based reference model checked every cycle,
// plus literal expectations for startup, backpressure, redirects, wrap and reset.
module tb_fetch_stage;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .id_valid_o       (id_valid),
    .id_ready_i       (id_ready),
    .id_pc_o          (id_pc),
    .id_instr_o       (id_instr)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned last_due = 0;

  // Memory: outstanding requests with the cycle their response is due.
  logic [31:0] mq_addr [$];
  int unsigned mq_due  [$];

  // Reference model: pending PCs awaiting data, ready {pc, instr} pairs, drop count.
  logic [31:0] m_pc;
  logic [31:0] pend_pc [$];
  logic [31:0] rdy_pc  [$];
  logic [31:0] rdy_ins [$];
  int          m_drop;

  logic        s_req_v, s_id_v;
  logic [31:0] s_req_addr, s_id_pc, s_id_instr;
  logic [31:0] xlog [$];
  logic [31:0] alog [$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive the response, compare outputs, advance model and memory.
  task automatic step();
    logic        e_req_v, e_id_v, acc, xf;
    logic [31:0] p;
    int unsigned due;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    #1;
    e_req_v = reset_n && !redirect_valid &&
              ((rdy_pc.size() + pend_pc.size() + m_drop) < int'(DEPTH));
    e_id_v  = reset_n && (rdy_pc.size() > 0);
    chk1("req_valid", imem_req_valid, e_req_v);
    if (reset_n) chk("req_addr", imem_req_addr, m_pc);
    chk1("id_valid", id_valid, e_id_v);
    if (e_id_v) begin
      chk("id_pc", id_pc, rdy_pc[0]);
      chk("id_instr", id_instr, rdy_ins[0]);
    end
    s_req_v    = imem_req_valid;
    s_req_addr = imem_req_addr;
    s_id_v     = id_valid;
    s_id_pc    = id_pc;
    s_id_instr = id_instr;

    if (imem_req_valid && imem_req_ready) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
    end

    acc = e_req_v && imem_req_ready;
    xf  = e_id_v && id_ready;
    if (xf) xlog.push_back(rdy_pc[0]);
    if (acc) alog.push_back(m_pc);
    if (reset_n && imem_rsp_valid)
      chk1("rsp_has_request", (m_drop > 0) || (pend_pc.size() > 0), 1'b1);

    if (!reset_n) begin
      pend_pc.delete(); rdy_pc.delete(); rdy_ins.delete();
      m_drop = 0;
      m_pc   = RESET_PC;
    end else if (redirect_valid) begin
      m_drop = m_drop + pend_pc.size() - (imem_rsp_valid ? 1 : 0);
      pend_pc.delete(); rdy_pc.delete(); rdy_ins.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (xf) begin
        void'(rdy_pc.pop_front());
        void'(rdy_ins.pop_front());
      end
      if (imem_rsp_valid) begin
        if (m_drop > 0) begin
          m_drop--;
        end else if (pend_pc.size() > 0) begin
          p = pend_pc.pop_front();
          rdy_pc.push_back(p);
          rdy_ins.push_back(imem_rsp_data);
        end
      end
      if (acc) begin
        pend_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_xlog(input int n, input int budget);
    for (int i = 0; i < budget && xlog.size() < n; i++) step();
  endtask

  task automatic run_alog(input int n, input int budget);
    for (int i = 0; i < budget && alog.size() < n; i++) step();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    chk1("redirect_no_req", s_req_v, 1'b0);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rq_pat, id_pat;
    logic [31:0] saved;
    logic        found;
    reset_n        = 1'b0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    m_drop         = 0;
    m_pc           = RESET_PC;

    step();
    chk1("reset_req_valid", s_req_v, 1'b0);
    chk1("reset_id_valid", s_id_v, 1'b0);
    step();
    reset_n = 1'b1;

    // Startup: first accept, then id_valid two cycles later.
    step();
    chk1("first_req_valid", s_req_v, 1'b1);
    chk("first_req_addr", s_req_addr, 32'h0000_0100);
    step();
    chk1("startup_id_idle", s_id_v, 1'b0);
    chk("second_req_addr", s_req_addr, 32'h0000_0104);
    step();
    chk1("first_id_valid", s_id_v, 1'b1);
    chk("first_id_pc", s_id_pc, 32'h0000_0100);
    chk("first_id_instr", s_id_instr, 32'hC0DE_0113);

    // Backpressure while 0x104 is presented.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_id_valid", s_id_v, 1'b1);
      chk("bp_id_pc", s_id_pc, 32'h0000_0104);
      chk("bp_id_instr", s_id_instr, 32'hC0DE_0117);
      if (i > 0) chk1("bp_no_req_when_full", s_req_v, 1'b0);
    end
    id_ready = 1'b1;
    xlog.delete();
    alog.delete();
    run_xlog(4, 20);
    chk("resume_req_addr", (alog.size() > 0) ? alog[0] : 32'hDEAD_BEEF, 32'h0000_010C);
    for (int i = 0; i < 4; i++)
      chk("resume_xfer_seq", (xlog.size() > i) ? xlog[i] : 32'hDEAD_BEEF,
          32'h0000_0104 + 32'(4 * i));

    // Throttled request acceptance and decode readiness.
    rq_pat = 16'b1011_0010_1110_0101;
    id_pat = 16'b1101_1001_0111_0110;
    for (int i = 0; i < 16; i++) begin
      imem_req_ready = rq_pat[i];
      id_ready       = id_pat[i];
      step();
    end
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Redirect with two requests in flight, memory latency 3.
    lat = 3;
    for (int i = 0; i < 40 && pend_pc.size() != 2; i++) step();
    chk("two_in_flight", pend_pc.size(), 2);
    do_redirect(32'h0000_0200);
    xlog.delete();
    run_xlog(2, 40);
    chk("redir_first_pc", (xlog.size() > 0) ? xlog[0] : 32'hDEAD_BEEF, 32'h0000_0200);
    chk("redir_second_pc", (xlog.size() > 1) ? xlog[1] : 32'hDEAD_BEEF, 32'h0000_0204);

    // Redirect coinciding with a response and a decode transfer.
    lat = 1;
    for (int i = 0; i < 10; i++) step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rdy_pc.size() > 0 && mq_due.size() > 0 && mq_due[0] == cyc) found = 1'b1;
      else step();
    end
    chk1("coinc_found", found, 1'b1);
    xlog.delete();
    do_redirect(32'h0000_0400);
    chk("coinc_xfer_once", xlog.size(), 1);
    saved = (xlog.size() > 0) ? xlog[0] : 32'hDEAD_BEEF;
    chk("coinc_drop_zero", m_drop, 0);
    xlog.delete();
    run_xlog(2, 30);
    chk("coinc_next_pc", (xlog.size() > 0) ? xlog[0] : 32'hDEAD_BEEF, 32'h0000_0400);
    chk("coinc_next_pc2", (xlog.size() > 1) ? xlog[1] : 32'hDEAD_BEEF, 32'h0000_0404);
    chk1("coinc_no_repeat", (xlog.size() > 0) && (xlog[0] == saved), 1'b0);

    // Misaligned redirect target.
    for (int i = 0; i < 3; i++) step();
    do_redirect(32'h0000_0303);
    step();
    chk("misaligned_addr", s_req_addr, 32'h0000_0300);

    // PC wrap at the top of the address space.
    for (int i = 0; i < 3; i++) step();
    do_redirect(32'hFFFF_FFFC);
    alog.delete();
    run_alog(2, 30);
    chk("wrap_req0", (alog.size() > 0) ? alog[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_req1", (alog.size() > 1) ? alog[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Reset mid-stream with buffered entries and a quiescent memory.
    id_ready = 1'b0;
    for (int i = 0; i < 30 && !(rdy_pc.size() == 2 && mq_due.size() == 0); i++) step();
    chk("full_before_reset", rdy_pc.size(), 2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk1("post_reset_id_valid", s_id_v, 1'b0);
    chk1("post_reset_req_valid", s_req_v, 1'b1);
    chk("post_reset_req_addr", s_req_addr, 32'h0000_0100);
    id_ready = 1'b1;
    xlog.delete();
    run_xlog(2, 20);
    chk("post_reset_pc0", (xlog.size() > 0) ? xlog[0] : 32'hDEAD_BEEF, 32'h0000_0100);
    chk("post_reset_pc1", (xlog.size() > 1) ? xlog[1] : 32'hDEAD_BEEF, 32'h0000_0104);
    for (int i = 0; i < 5; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
